// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the asynchronous SRAM controller.
//   state_e         : controller FSM states
//   RdCyclesDefault : default read strobe width in clk cycles
//   WrCyclesDefault : default write strobe width in clk cycles
//   byte_merge()    : overlay enabled bytes of a new word onto an old word
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWs,
    StWp,
    StWh,
    StDone
  } state_e;

  localparam int unsigned RdCyclesDefault = 2;
  localparam int unsigned WrCyclesDefault = 2;

  // Bytes with be[i]=1 come from new_word, the rest from old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller with a valid/ready host port.
// One request is taken in IDLE, run through the SRAM strobe sequence and
// acknowledged with a one-cycle rsp_valid pulse.
//
// Configuration macro SRAM_CTRL_NATIVE_BE_EN:
//   defined   : SRAM byte enables are driven from the request (partial writes
//               go straight to the write path).
//   undefined : byte enables tied active; partial writes run read-modify-write.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   host handshake; ready only in IDLE
//   req_we, req_addr      1=write/0=read, 20-bit word address
//   req_wdata, req_be     write data, active-high byte enables
//   rsp_valid, rsp_rdata  completion pulse, last read data
//   ram_data              bidirectional SRAM data bus
//   ram_addr, ram_be_n    SRAM address, active-low byte enables
//   ram_ce_n/oe_n/we_n    SRAM chip select, output enable, write enable
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned RD_CYCLES = RdCyclesDefault,
  parameter int unsigned WR_CYCLES = WrCyclesDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [19:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  inout  wire  [31:0] ram_data,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  // Counter loads: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] RdLoad = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WrLoad = 4'(WR_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        need_rd;
  logic        bus_oe;

  // A request enters the read phase when it is a read, or (without native
  // byte enables) a partial write that must fetch the old word first.
`ifdef SRAM_CTRL_NATIVE_BE_EN
  assign need_rd = ~req_we;
`else
  assign need_rd = ~req_we | (req_be != 4'hF);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          we_d    = req_we;
          if (need_rd) begin
            state_d = StRd;
            cnt_d   = RdLoad;
          end else begin
            state_d = StWs;
          end
        end
      end
      StRd: begin
        if (cnt_q == 4'd0) begin
          if (we_q) begin
            // RMW fetch: fold the old word into the write data, keep rsp_rdata.
            wdata_d = byte_merge(ram_data, wdata_q, be_q);
            state_d = StWs;
          end else begin
            rdata_d = ram_data;
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWs: begin
        state_d = StWp;
        cnt_d   = WrLoad;
      end
      StWp: begin
        if (cnt_q == 4'd0) begin
          state_d = StWh;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWh:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus_oe    = (state_q == StWs) || (state_q == StWp) || (state_q == StWh);
  assign ram_data  = bus_oe ? wdata_q : 'z;
  assign ram_addr  = addr_q;
  assign ram_ce_n  = ~((state_q == StRd) || bus_oe);
  assign ram_oe_n  = ~(state_q == StRd);
  assign ram_we_n  = ~(state_q == StWp);
  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign rsp_rdata = rdata_q;

`ifdef SRAM_CTRL_NATIVE_BE_EN
  assign ram_be_n = ((state_q == StRd) || bus_oe) ? ~be_q : 4'hF;
`else
  assign ram_be_n = 4'h0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: randomized host traffic against a
// word-array reference model, plus a second instance with RD=4/WR=1 for
// strobe-width checks.
module tb_sram_ctrl;

  localparam int unsigned RdC = 2;
  localparam int unsigned WrC = 2;
`ifdef SRAM_CTRL_NATIVE_BE_EN
  localparam bit Native = 1'b1;
`else
  localparam bit Native = 1'b0;
`endif
  localparam logic [3:0] IdleBeN = Native ? 4'hF : 4'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT
  logic        req_valid, req_ready, req_we, rsp_valid;
  logic [19:0] req_addr, ram_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic [3:0]  req_be, ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n;
  wire  [31:0] ram_data;

  sram_ctrl #(.RD_CYCLES(RdC), .WR_CYCLES(WrC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_data(ram_data),
    .ram_addr(ram_addr), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  // SRAM model: 256 words, cleared on reset, reads while ce/oe low.
  logic [31:0] mem [256];
  assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] : 'z;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (!ram_ce_n && !ram_we_n) begin
      for (int b = 0; b < 4; b++) begin
        if (!ram_be_n[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
      end
    end
  end

  // Second DUT for strobe widths
  logic        p_req_valid, p_req_ready, p_req_we, p_rsp_valid;
  logic [19:0] p_req_addr, p_ram_addr;
  logic [31:0] p_req_wdata, p_rsp_rdata;
  logic [3:0]  p_req_be, p_ram_be_n;
  logic        p_ram_ce_n, p_ram_oe_n, p_ram_we_n;
  wire  [31:0] p_ram_data;

  sram_ctrl #(.RD_CYCLES(4), .WR_CYCLES(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .req_valid(p_req_valid), .req_ready(p_req_ready),
    .req_we(p_req_we), .req_addr(p_req_addr), .req_wdata(p_req_wdata),
    .req_be(p_req_be), .rsp_valid(p_rsp_valid), .rsp_rdata(p_rsp_rdata),
    .ram_data(p_ram_data), .ram_addr(p_ram_addr), .ram_be_n(p_ram_be_n),
    .ram_ce_n(p_ram_ce_n), .ram_oe_n(p_ram_oe_n), .ram_we_n(p_ram_we_n)
  );
  assign p_ram_data = (!p_ram_ce_n && !p_ram_oe_n) ? 32'h5A5A_1234 : 'z;

  // Scoreboard
  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          acc;
    logic [19:0] addr;
    logic [3:0]  be;
  } exp_t;
  exp_t q[$];

  logic [31:0] ref_mem [256];
  logic [31:0] last_rd;
  int checks = 0;
  int errors = 0;
  int n_rsp  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    last_rd = '0;
    q.delete();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("oe_we_overlap", 32'(!ram_oe_n && !ram_we_n), 32'd0);
        if (q.size() == 0) begin
          chk("idle_ce_n", 32'(ram_ce_n), 32'd1);
          chk("idle_be_n", 32'(ram_be_n), 32'(IdleBeN));
        end else if (q[0].acc <= cyc) begin
          chk("ready_busy", 32'(req_ready), 32'd0);
          if (!ram_ce_n) begin
            chk("ram_addr", 32'(ram_addr), 32'(q[0].addr));
            chk("ram_be_n", 32'(ram_be_n), Native ? 32'(~q[0].be) : 32'd0);
          end
        end
        if (rsp_valid) begin
          n_rsp++;
          if (q.size() == 0) begin
            chk("spurious_rsp", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("rsp_rdata", rsp_rdata, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic issue(input bit we, input logic [19:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.acc  = cyc + 1;
    e.addr = a;
    e.be   = be;
    if (we) begin
      ref_mem[a[7:0]] = merge_ref(ref_mem[a[7:0]], d, be);
      e.rdata = last_rd;
      e.lat   = (!Native && be != 4'hF) ? int'(RdC + WrC + 3) : int'(WrC + 3);
    end else begin
      last_rd = ref_mem[a[7:0]];
      e.rdata = last_rd;
      e.lat   = int'(RdC + 1);
    end
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle_req();
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic param_txn(input bit we);
    int acc, n, oe_cnt, we_cnt;
    @(negedge clk);
    chk("p_ready", 32'(p_req_ready), 32'd1);
    p_req_valid = 1'b1;
    p_req_we    = we;
    p_req_addr  = 20'h00055;
    p_req_wdata = 32'h0BAD_F00D;
    p_req_be    = 4'hF;
    acc = cyc + 1;
    @(negedge clk);
    p_req_valid = 1'b0;
    n = 0; oe_cnt = 0; we_cnt = 0;
    while (!p_rsp_valid && n < 40) begin
      if (!p_ram_oe_n) oe_cnt++;
      if (!p_ram_we_n) we_cnt++;
      chk("p_oe_we_overlap", 32'(!p_ram_oe_n && !p_ram_we_n), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("p_rsp_seen", 32'(p_rsp_valid), 32'd1);
    chk("p_latency", 32'(cyc - acc + 1), we ? 32'd4 : 32'd5);
    chk("p_oe_cycles", 32'(oe_cnt), we ? 32'd0 : 32'd4);
    chk("p_we_cycles", 32'(we_cnt), we ? 32'd1 : 32'd0);
    if (!we) chk("p_rdata", p_rsp_rdata, 32'h5A5A_1234);
  endtask

  initial begin
    int n, n0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    p_req_valid = 1'b0; p_req_we = 1'b0; p_req_addr = '0; p_req_wdata = '0; p_req_be = '0;
    model_reset();
    #1;
    chk("rst_ce_n", 32'(ram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
    chk("rst_we_n", 32'(ram_we_n), 32'd1);
    chk("rst_be_n", 32'(ram_be_n), 32'(IdleBeN));
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fork
      monitor();
    join_none

    // Full write then read back
    issue(1'b1, 20'h00010, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 20'h00010, 32'h0, 4'hF);
    drain();
    chk("rd_deadbeef", rsp_rdata, 32'hDEAD_BEEF);

    // Partial write
    issue(1'b1, 20'h00020, 32'h1122_3344, 4'hF);
    issue(1'b1, 20'h00020, 32'h0000_AA00, 4'b0010);
    issue(1'b0, 20'h00020, 32'h0, 4'hF);
    drain();
    chk("rd_partial", rsp_rdata, 32'h1122_AA44);

    // Zero byte-enable write leaves the word intact
    issue(1'b1, 20'h00020, 32'hFFFF_FFFF, 4'h0);
    issue(1'b0, 20'h00020, 32'h0, 4'h0);
    drain();

    // Four back-to-back reads with valid held high
    n0 = n_rsp;
    for (int i = 0; i < 4; i++) issue(1'b0, 20'(i * 16), 32'h0, 4'hF);
    drain();
    chk("b2b_rsp_count", 32'(n_rsp - n0), 32'd4);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom_range(0, 1)), 20'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
      if ($urandom_range(0, 1) == 1) idle_req();
    end
    drain();

    // Reset while the write strobe is active
    issue(1'b1, 20'h00030, 32'h1234_5678, 4'hF);
    idle_req();
    n = 0;
    while (ram_we_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wp_reached", 32'(ram_we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_n", 32'(ram_we_n), 32'd1);
    chk("abort_ce_n", 32'(ram_ce_n), 32'd1);
    chk("abort_oe_n", 32'(ram_oe_n), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_addr", 32'(ram_addr), 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      issue(1'($urandom_range(0, 1)), 20'($urandom_range(48, 55)), $urandom,
            4'($urandom_range(0, 15)));
    end
    drain();

    // Strobe widths with RD_CYCLES=4, WR_CYCLES=1
    param_txn(1'b0);
    param_txn(1'b1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter RD_CYCLES, default 2, number of clk cycles ram_oe_n/ram_ce_n are held low per read (legal range 1..15).
REQ-002 SHALL have parameter WR_CYCLES, default 2, number of clk cycles ram_we_n is held low per write (legal range 1..15).
REQ-003 SHALL use one clock and an asynchronous, active-low reset. Ports: clk  input  1  clock (clk_50M domain); rst_n  input  1  asynchronous reset, active low.
REQ-004 SHALL have ports req_valid  input  1  host request valid; req_ready  output  1  controller can accept a request.
REQ-005 SHALL have ports req_we  input  1  1=write, 0=read; req_addr  input  20  word address; req_wdata  input  32  write data; req_be  input  4  byte enables, active high.
REQ-006 SHALL have ports rsp_valid  output  1  one-cycle completion pulse; rsp_rdata  output  32  read data.
REQ-007 SHALL have ports ram_data  inout  32  SRAM data bus; ram_addr  output  20  SRAM address; ram_be_n  output  4  byte enables, active low; ram_ce_n, ram_oe_n, ram_we_n  output  1 each  chip select, output enable, write enable, all active low.

Function
REQ-008 SHALL implement states IDLE, RD, WS, WP, WH, DONE; req_ready=1 only in IDLE.
REQ-009 SHALL accept a request on the edge where req_valid&&req_ready, then latch addr/wdata/be/we; host inputs are don't-care afterwards.
REQ-010 Read: IDLE->RD for exactly RD_CYCLES cycles with ce_n=0, oe_n=0, we_n=1, bus not driven; ram_data is captured into rsp_rdata on the last RD edge; ->DONE.
REQ-011 Write: WS 1 cycle (ce_n=0, addr/data driven, we_n=1), WP WR_CYCLES cycles (we_n=0), WH 1 cycle (we_n=1, ce_n=0, data still driven); ->DONE.
REQ-012 DONE SHALL last 1 cycle with rsp_valid=1, req_ready=0, then ->IDLE; read latency accept->rsp_valid = RD_CYCLES+1, write = WR_CYCLES+3 (native BE).
REQ-013 ram_data SHALL be driven only in WS, WP, WH; high-Z in all other states and in reset; oe_n and we_n never both low.
REQ-014 rsp_rdata SHALL change only on read capture; write completions leave it unchanged.
REQ-015 ram_addr SHALL hold the latched address from accept through DONE; it holds its last value in IDLE.
REQ-016 A request with req_be=4'h0 SHALL complete as a normal transaction with all ram_be_n=1 (no byte written or enabled).

Reset
REQ-017 On rst_n=0 SHALL immediately force ce_n=oe_n=we_n=1, ram_be_n=4'hF (4'h0 without macro), ram_addr=0, bus high-Z, rsp_valid=0, rsp_rdata=0, state IDLE.
REQ-018 Reset mid-transaction SHALL abort with no rsp_valid; req_ready=1 on the first edge after rst_n rises.

Configuration
REQ-019 Macro SRAM_CTRL_NATIVE_BE_EN defined: ram_be_n = ~be during RD/WS/WP/WH, 4'hF otherwise; partial writes use the write path directly.
REQ-020 Macro undefined: ram_be_n tied 4'h0; a write with be!=4'hF SHALL run read-modify-write: RD (RD_CYCLES), merge latched wdata into read word per be, then WS/WP/WH, DONE; latency RD_CYCLES+WR_CYCLES+3; rsp_rdata not updated by the RMW read.

Structure
REQ-021 Package sram_ctrl_pkg SHALL hold the state enum, default RD_CYCLES/WR_CYCLES constants, and the byte-merge function.
REQ-022 No sub-module; a single cycle counter (4 bits) SHALL be shared by RD and WP.

Verification
REQ-023 Write addr 0x00010, data 0xDEADBEEF, be 4'hF, then read 0x00010 -> rsp_rdata=0xDEADBEEF, rsp_valid at accept+3 for the read.
REQ-024 Write 0x11223344 to 0x00020, then be=4'b0010 data 0x0000AA00 -> read returns 0x1122AA44, in both macro settings; without macro the partial write completes at accept+7.
REQ-025 Back-to-back req_valid held high for 4 reads -> one accept per transaction, req_ready low from accept to DONE, exactly 4 rsp_valid pulses.
REQ-026 Assert rst_n=0 during WP -> we_n/ce_n=1 within the same cycle, bus high-Z, no rsp_valid; memory content at the target address is don't-care.
REQ-027 RD_CYCLES=4, WR_CYCLES=1 -> oe_n low exactly 4 cycles, we_n low exactly 1 cycle; checker flags any cycle with oe_n=0 and we_n=0 or with the bus driven while oe_n=0.
